// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
// Holds the FSM state enum, ALU control codes and perf counter width.
package alu_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam int PERF_CNT_W = 16;

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin picker: one-hot grant, favouring the requester
// that was not granted last. Ports: valid[1:0], last in; grant[1:0], any out.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant,
   output logic       any
);

   always_comb begin
      grant = 2'b00;
      any   = |valid;
      if (valid == 2'b11)
         grant = last ? 2'b01 : 2'b10;
      else
         grant = valid;
   end

endmodule

// File: rtl/alu_sched.sv
// Shares one combinational ALU between two requesters: round-robin
// accept, registered ALU operands, captured result returned via a
// valid/ready response. Ports: req_* in, alu_* to/from ALU, rsp_* out.
// Macro ALU_SCHED_PERF_EN adds saturating per-requester accept counters
// on perf_cnt0/perf_cnt1.
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [DATA_WIDTH-1:0] req0_op1,
   input  logic [DATA_WIDTH-1:0] req0_op2,
   input  logic [CTRL_WIDTH-1:0] req0_ctrl,
   input  logic [DATA_WIDTH-1:0] req1_op1,
   input  logic [DATA_WIDTH-1:0] req1_op2,
   input  logic [CTRL_WIDTH-1:0] req1_ctrl,
   output logic [DATA_WIDTH-1:0] alu_op1,
   output logic [DATA_WIDTH-1:0] alu_op2,
   output logic [CTRL_WIDTH-1:0] alu_ctrl,
   input  logic [DATA_WIDTH-1:0] alu_out,
   input  logic                  alu_eq,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_id,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic                  rsp_eq
`ifdef ALU_SCHED_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] perf_cnt0,
   output logic [PERF_CNT_W-1:0] perf_cnt1
`endif
);

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] op1_q;
   logic [DATA_WIDTH-1:0] op2_q;
   logic [CTRL_WIDTH-1:0] ctrl_q;
   logic                  id_q;
   logic                  last_q;
   logic [DATA_WIDTH-1:0] res_q;
   logic                  eq_q;
   logic [1:0]            grant;
   logic                  any;
   logic                  accept;

   rr_arb2 u_arb (
      .valid (req_valid),
      .last  (last_q),
      .grant (grant),
      .any   (any)
   );

   assign accept     = (state == IDLE) && any;
   assign req_ready  = (state == IDLE) ? grant : 2'b00;
   assign alu_op1    = op1_q;
   assign alu_op2    = op2_q;
   assign alu_ctrl   = ctrl_q;
   assign rsp_valid  = (state == RESP);
   assign rsp_id     = id_q;
   assign rsp_result = res_q;
   assign rsp_eq     = eq_q;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op1_q  <= '0;
         op2_q  <= '0;
         ctrl_q <= '0;
         id_q   <= 1'b0;
         last_q <= 1'b1;
         res_q  <= '0;
         eq_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op1_q  <= grant[1] ? req1_op1  : req0_op1;
            op2_q  <= grant[1] ? req1_op2  : req0_op2;
            ctrl_q <= grant[1] ? req1_ctrl : req0_ctrl;
            id_q   <= grant[1];
            last_q <= grant[1];
         end
         if (state == EXEC) begin
            res_q <= alu_out;
            eq_q  <= alu_eq;
         end
      end
   end

`ifdef ALU_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cnt0 <= '0;
         perf_cnt1 <= '0;
      end else begin
         if (accept && grant[0] && perf_cnt0 != '1)
            perf_cnt0 <= perf_cnt0 + 1'b1;
         if (accept && grant[1] && perf_cnt1 != '1)
            perf_cnt1 <= perf_cnt1 + 1'b1;
      end
   end
`else
   // no performance counters in this build
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched with a behavioural ALU.
// Steps: reset, single op, first contention, alternation, backpressure, eq, reset mid-EXEC.
module tb_alu_sched;
   import alu_sched_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic [2:0]  req0_ctrl, req1_ctrl;
   logic [31:0] alu_op1, alu_op2, alu_out;
   logic [2:0]  alu_ctrl;
   logic        alu_eq;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_eq;
   logic [31:0] rsp_result;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always_comb begin
      alu_out = 32'h0;
      alu_eq  = (alu_op1 == alu_op2);
      case (alu_ctrl)
         ALU_ADD: alu_out = alu_op1 + alu_op2;
         ALU_SUB: alu_out = alu_op1 - alu_op2;
         ALU_AND: alu_out = alu_op1 & alu_op2;
         ALU_OR:  alu_out = alu_op1 | alu_op2;
         ALU_SLT: alu_out = {31'b0, $signed(alu_op1) < $signed(alu_op2)};
         default: alu_out = 32'h0;
      endcase
   end

   alu_sched dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
      .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
      .alu_out(alu_out), .alu_eq(alu_eq),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_eq(rsp_eq)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"},  32'(req_ready), 32'h0);
      chk({tag, "_rvalid"}, 32'(rsp_valid), 32'h0);
      chk({tag, "_rid"},    32'(rsp_id), 32'h0);
      chk({tag, "_rres"},   rsp_result, 32'h0);
      chk({tag, "_req"},    32'(rsp_eq), 32'h0);
      chk({tag, "_aop1"},   alu_op1, 32'h0);
      chk({tag, "_aop2"},   alu_op2, 32'h0);
      chk({tag, "_actrl"},  32'(alu_ctrl), 32'h0);
   endtask

   initial begin
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      req0_op1 = 0; req0_op2 = 0; req0_ctrl = ALU_ADD;
      req1_op1 = 0; req1_op2 = 0; req1_ctrl = ALU_ADD;
      rst_n = 1'b0;
      #2;
      chk_zero("rst");
      tick();
      rst_n = 1'b1;

      // single ADD from requester 0
      req_valid = 2'b01;
      req0_op1 = 32'd5; req0_op2 = 32'd7; req0_ctrl = ALU_ADD;
      #1;
      chk("add_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      chk("add_exec_op1", alu_op1, 32'd5);
      chk("add_exec_rv", 32'(rsp_valid), 32'h0);
      tick();
      chk("add_rv", 32'(rsp_valid), 32'h1);
      chk("add_id", 32'(rsp_id), 32'h0);
      chk("add_res", rsp_result, 32'd12);
      chk("add_eq", 32'(rsp_eq), 32'h0);
      tick();
      chk("add_rv_drop", 32'(rsp_valid), 32'h0);

      // simultaneous first requests after reset
      do_reset();
      req0_op1 = 32'd10; req0_op2 = 32'd3; req0_ctrl = ALU_ADD;
      req1_op1 = 32'd10; req1_op2 = 32'd3; req1_ctrl = ALU_SUB;
      req_valid = 2'b11;
      #1;
      chk("first_ready0", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b10;
      tick();
      chk("first_id0", 32'(rsp_id), 32'h0);
      chk("first_res0", rsp_result, 32'd13);
      chk("first_ready_resp", 32'(req_ready), 32'h0);
      tick();
      chk("first_ready1", 32'(req_ready), 32'h2);
      tick();
      req_valid = 2'b00;
      tick();
      chk("first_id1", 32'(rsp_id), 32'h1);
      chk("first_res1", rsp_result, 32'd7);
      tick();

      // sustained contention: strict alternation starting with 0
      req0_op1 = 32'hF0F0_00FF; req0_op2 = 32'h0FF0_0F0F; req0_ctrl = ALU_AND;
      req1_op1 = 32'hF0F0_00FF; req1_op2 = 32'h0FF0_0F0F; req1_ctrl = ALU_OR;
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("alt_grant", 32'(req_ready), (i % 2) ? 32'h2 : 32'h1);
         tick();
         tick();
         chk("alt_id", 32'(rsp_id), 32'(i % 2));
         chk("alt_res", rsp_result,
             (i % 2) ? 32'hFFF0_0FFF : 32'h00F0_000F);
         tick();
      end
      req_valid = 2'b00;

      // backpressure on requester 1 using SLT
      rsp_ready = 1'b0;
      req1_op1 = 32'hFFFF_FFFF; req1_op2 = 32'd1; req1_ctrl = ALU_SLT;
      req_valid = 2'b10;
      #1;
      chk("bp_ready", 32'(req_ready), 32'h2);
      tick();
      req1_op1 = 32'd1; req1_op2 = 32'd1; req1_ctrl = ALU_ADD;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_rv", 32'(rsp_valid), 32'h1);
         chk("bp_res", rsp_result, 32'd1);
         chk("bp_ready0", 32'(req_ready), 32'h0);
         tick();
      end
      rsp_ready = 1'b1;
      chk("bp_rv_last", 32'(rsp_valid), 32'h1);
      tick();
      chk("bp_resume", 32'(req_ready), 32'h2);
      tick();
      req_valid = 2'b00;
      tick();
      chk("bp2_id", 32'(rsp_id), 32'h1);
      chk("bp2_res", rsp_result, 32'd2);
      tick();

      // equality through SUB
      req0_op1 = 32'hDEAD_BEEF; req0_op2 = 32'hDEAD_BEEF;
      req0_ctrl = ALU_SUB;
      req_valid = 2'b01;
      #1;
      chk("eq_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      tick();
      chk("eq_res", rsp_result, 32'h0);
      chk("eq_flag", 32'(rsp_eq), 32'h1);
      tick();

      // reset during EXEC drops the operation
      req1_op1 = 32'd100; req1_op2 = 32'd1; req1_ctrl = ALU_ADD;
      req_valid = 2'b10;
      tick();
      req_valid = 2'b00;
      chk("mid_exec_op1", alu_op1, 32'd100);
      rst_n = 1'b0;
      #1;
      chk_zero("mid_rst");
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
         tick();
      end
      req0_op1 = 32'd1; req0_op2 = 32'd2; req0_ctrl = ALU_ADD;
      req_valid = 2'b11;
      #1;
      chk("mid_ready0", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      tick();
      chk("mid_id", 32'(rsp_id), 32'h0);
      chk("mid_res", rsp_result, 32'd3);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Two-requester scheduler that shares the single combinational ALU between two masters, e.g. the main datapath and a branch/address helper.
- Arbitrates round-robin and accepts one operation per grant.
- Drives the ALU from registered operands, captures its result and eq flag, and returns them with a valid/ready response handshake.
- Sits between the requesters and the ALU instance; the ALU itself stays purely combinational.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the ALU's DATA_WIDTH.
- CTRL_WIDTH, 3, ALU control code width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester operation valid; bit i = requester i.
- req_ready  out  2  per-requester accept strobe.
- req0_op1, req0_op2  in  DATA_WIDTH  requester 0 operands.
- req0_ctrl  in  CTRL_WIDTH  requester 0 ALU control code.
- req1_op1, req1_op2  in  DATA_WIDTH  requester 1 operands.
- req1_ctrl  in  CTRL_WIDTH  requester 1 ALU control code.
- alu_op1, alu_op2  out  DATA_WIDTH  to ALU operand inputs.
- alu_ctrl  out  CTRL_WIDTH  to ALU control input.
- alu_out  in  DATA_WIDTH  ALU result.
- alu_eq  in  1  ALU equality flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester index of the response.
- rsp_result  out  DATA_WIDTH  captured ALU result.
- rsp_eq  out  1  captured eq flag.

Behaviour:
- Reset: async assert forces all of the following.
  - State = IDLE.
  - Operand, ctrl and response registers = 0, so alu_op1/alu_op2/alu_ctrl = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_eq = 0, req_ready = 0.
  - last_grant = 1, so requester 0 wins first.
  - An in-flight operation is dropped silently; no response is ever produced for it.
  - Deassertion is not required to be synchronised here; the top level synchronises it.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - grant = round-robin pick of req_valid.
  - If exactly one bit is set, that requester is granted.
  - If both are set, the requester that is not last_grant is granted.
  - req_ready[g] = 1 combinationally, only in IDLE and only for the granted requester; req_ready = 0 in every other state.
  - On accept, latch op1/op2/ctrl/id into registers, update last_grant = g, and go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC:
  - alu_op1/alu_op2/alu_ctrl come from the registers; these outputs are register-driven, never combinational from req inputs.
  - At the end of the cycle, capture alu_out into rsp_result and alu_eq into rsp_eq, then go to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_id, rsp_result and rsp_eq are held stable while rsp_ready = 0.
  - On rsp_valid && rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- Latency: accept at cycle N, rsp_valid at cycle N+2.
- Throughput: minimum 3 cycles per operation.
- Ctrl codes are passed through unchecked; the ALU defines the result for unsupported codes.
- Requesters must hold valid and operands stable until req_ready; dropping valid before ready is legal and simply withdraws the request.
- Both requesters valid every cycle yields a strict alternation of grants.

Optional Feature:
- Macro: ALU_SCHED_PERF_EN.
- Defined: adds outputs perf_cnt0 and perf_cnt1, each 16 bits.
  - Each counts accepted operations for its requester.
  - Counters saturate at 0xFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package alu_sched_pkg holds:
  - state enum (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - ALU ctrl constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101;
  - PERF_CNT_W=16.
- One sub-module, rr_arb2: 2-way round-robin picker with inputs valid[1:0] and last; outputs grant[1:0] (one-hot) and any.

Test Plan:
- Single ADD: req_valid=2'b01, req0 5+7 with ctrl ALU_ADD -> req_ready=2'b01 at cycle 0; rsp_valid at cycle 2 with rsp_id=0, rsp_result=12, rsp_eq=0.
- Simultaneous first requests after reset, both valid -> requester 0 served first, then requester 1; rsp_id sequence 0,1.
- Sustained contention, both valid for 4 operations -> grants alternate 0,1,0,1; no requester is served twice consecutively.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_result stable, req_ready=0 throughout; accept resumes the cycle after the handshake.
- Equality: op1=op2=0xDEADBEEF, ctrl ALU_SUB -> rsp_result=0, rsp_eq=1.
- Reset mid-EXEC: rst_n low for 1 cycle during EXEC -> all outputs 0 immediately; no rsp_valid for the dropped operation; the next request is served by requester 0 first.
